// File: rtl/jk_pkg.sv
// Shared opcodes, FSM state type and count width for the JK command sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package jk_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_TGL  = 2'b11;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2
  } state_t;

  // Q the downstream flip-flop should hold once a command has been applied.
  // A toggle held for N edges flips Q N times, so only the parity of N matters.
  function automatic logic next_q(input logic [1:0] op, input logic q, input logic hold_odd);
    logic r;
    r = q;
    case (op)
      OP_CLR:  r = 1'b0;
      OP_SET:  r = 1'b1;
      OP_TGL:  r = q ^ hold_odd;
      default: r = q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Synchronous command FIFO, DEPTH entries (power of two), W bits wide.
// Latency: a pushed entry is visible at the head one edge after the push.
// Backpressure: push ignored when full, pop ignored when empty; simultaneous push/pop both land.
// Ports: clk, rst (async active-low) | push, push_dat | pop, pop_dat (head) | full, empty.
module jk_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/jk_cmd_seq.sv
// Queues J/K commands, drives a downstream JK flip-flop and checks its Q against a model.
// Latency: HOLD_CYC + 2 cycles per command (IDLE pop, HOLD_CYC APPLY, 1 CHECK).
// Backpressure: cmd_ready = !full once out of reset; no bypass of a full FIFO.
// Ports: clk, rst (async active-low) | cmd_valid, cmd_op, cmd_ready | j, k, q_fb |
//        clr_err, exp_q, busy, mismatch, cmd_count.
module jk_cmd_seq
  import jk_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int HOLD_CYC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  output logic             cmd_ready,
  output logic             j,
  output logic             k,
  input  logic             q_fb,
  input  logic             clr_err,
  output logic             exp_q,
  output logic             busy,
  output logic             mismatch,
  output logic [CNT_W-1:0] cmd_count
);

  localparam logic HOLD_ODD = (HOLD_CYC % 2) != 0;

  state_t     state;
  logic [3:0] hold_cnt;
  logic [1:0] cur_op;
  logic [1:0] head_op;
  logic       rdy_en;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;

  // rdy_en keeps cmd_ready low throughout reset and rises on the first edge after it.
  assign cmd_ready = rdy_en & ~full;
  assign push      = cmd_valid & cmd_ready;
  assign pop       = (state == IDLE) & ~empty;
  assign busy      = (state != IDLE);

  jk_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (2)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (cmd_op),
    .pop      (pop),
    .pop_dat  (head_op),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      cur_op    <= OP_HOLD;
      j         <= 1'b0;
      k         <= 1'b0;
      exp_q     <= 1'b0;
      mismatch  <= 1'b0;
      cmd_count <= '0;
      rdy_en    <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      // A fresh mismatch in CHECK below overrides this clear.
      if (clr_err) mismatch <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            {j, k}   <= head_op;
            cur_op   <= head_op;
            hold_cnt <= 4'(HOLD_CYC);
            state    <= APPLY;
          end else begin
            {j, k} <= 2'b00;
          end
        end
        APPLY: begin
          hold_cnt <= hold_cnt - 1'b1;
          if (hold_cnt == 4'd1) begin
            {j, k} <= 2'b00;
            exp_q  <= next_q(cur_op, exp_q, HOLD_ODD);
            state  <= CHECK;
          end
        end
        CHECK: begin
          if (q_fb != exp_q) mismatch <= 1'b1;
          cmd_count <= cmd_count + 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_cmd_seq.sv
// Randomised bench: two sequencers (HOLD_CYC 1 and 2) share stimulus, each drives its own JK flip-flop.
// Latency: outputs compared every cycle against a per-instance command-timeline model.
// Backpressure: model tracks FIFO occupancy and ready independently per instance.
module tb_jk_cmd_seq;

  localparam int DEPTH = 4;
  localparam int NCYC  = 4000;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic       clr_err;
  logic [1:0] rdy, jo, ko, expq, busyo, miso, ffq, inj, qfb;
  logic [7:0] cnto [2];

  always #5 clk = ~clk;

  assign qfb = ffq ^ inj;

  jk_cmd_seq #(.DEPTH(DEPTH), .HOLD_CYC(1)) u_dut0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(rdy[0]),
    .j(jo[0]), .k(ko[0]), .q_fb(qfb[0]), .clr_err(clr_err), .exp_q(expq[0]),
    .busy(busyo[0]), .mismatch(miso[0]), .cmd_count(cnto[0])
  );

  jk_cmd_seq #(.DEPTH(DEPTH), .HOLD_CYC(2)) u_dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(rdy[1]),
    .j(jo[1]), .k(ko[1]), .q_fb(qfb[1]), .clr_err(clr_err), .exp_q(expq[1]),
    .busy(busyo[1]), .mismatch(miso[1]), .cmd_count(cnto[1])
  );

  // Downstream JK flip-flops, sharing the sequencer reset.
  always @(posedge clk or negedge rst) begin
    if (!rst) ffq <= 2'b00;
    else begin
      for (int u = 0; u < 2; u++) begin
        case ({jo[u], ko[u]})
          2'b10:   ffq[u] <= 1'b1;
          2'b01:   ffq[u] <= 1'b0;
          2'b11:   ffq[u] <= ~ffq[u];
          default: ;
        endcase
      end
    end
  end

  // Reference model: a queue of pending ops plus the age (cycles since pop) of the one in service.
  // Age 1..H: J/K driven; age H+1: check cycle; age 0: nothing in service.
  int         m_n   [2];
  int         m_rd  [2];
  int         m_age [2];
  int         m_cnt [2];
  logic [1:0] m_buf [2][DEPTH];
  logic [1:0] m_op  [2];
  logic       m_exp [2];
  logic       m_mis [2];
  logic       m_rdy [2];

  int n_vec = 0;
  int n_err = 0;

  function automatic int hold_of(input int u);
    return (u == 0) ? 1 : 2;
  endfunction

  task automatic chk_dat(input string tag, input int u, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s inst%0d t=%0t got=%0h want=%0h", tag, u, $time, got, want);
    end
  endtask

  task automatic model_reset(input int u);
    m_n[u] = 0; m_rd[u] = 0; m_age[u] = 0; m_cnt[u] = 0;
    m_op[u] = 2'b00; m_exp[u] = 1'b0; m_mis[u] = 1'b0; m_rdy[u] = 1'b0;
  endtask

  task automatic check_outs(input int u);
    int   h;
    logic [1:0] want_jk;
    h = hold_of(u);
    want_jk = (m_age[u] >= 1 && m_age[u] <= h) ? m_op[u] : 2'b00;
    chk_dat("jk",        u, 32'({jo[u], ko[u]}), 32'(want_jk));
    chk_dat("busy",      u, 32'(busyo[u]),       32'(m_age[u] != 0));
    chk_dat("exp_q",     u, 32'(expq[u]),        32'(m_exp[u]));
    chk_dat("mismatch",  u, 32'(miso[u]),        32'(m_mis[u]));
    chk_dat("cmd_count", u, 32'(cnto[u]),        32'(m_cnt[u] % 256));
    chk_dat("cmd_ready", u, 32'(rdy[u]),         32'(m_rdy[u] && (m_n[u] < DEPTH)));
  endtask

  // Advance the model across the coming rising edge using the inputs now driven.
  task automatic model_step(input int u);
    int   h;
    logic push_ok;
    logic q_now;
    h       = hold_of(u);
    push_ok = cmd_valid && m_rdy[u] && (m_n[u] < DEPTH);
    q_now   = ffq[u] ^ inj[u];
    if (m_age[u] == h + 1 && q_now != m_exp[u]) m_mis[u] = 1'b1;
    else if (clr_err)                            m_mis[u] = 1'b0;
    if (m_age[u] == 0) begin
      if (m_n[u] > 0) begin
        m_op[u]  = m_buf[u][m_rd[u]];
        m_rd[u]  = (m_rd[u] + 1) % DEPTH;
        m_n[u]   = m_n[u] - 1;
        m_age[u] = 1;
      end
    end else if (m_age[u] == h + 1) begin
      m_cnt[u] = (m_cnt[u] + 1) % 256;
      m_age[u] = 0;
    end else begin
      if (m_age[u] == h) begin
        case (m_op[u])
          2'b01:   m_exp[u] = 1'b0;
          2'b10:   m_exp[u] = 1'b1;
          2'b11:   m_exp[u] = m_exp[u] ^ (h % 2 == 1);
          default: ;
        endcase
      end
      m_age[u] = m_age[u] + 1;
    end
    if (push_ok) begin
      m_buf[u][(m_rd[u] + m_n[u]) % DEPTH] = cmd_op;
      m_n[u] = m_n[u] + 1;
    end
    m_rdy[u] = 1'b1;
  endtask

  logic [1:0] dir_op [4];
  int         rst_hold;
  int         wait_cnt;
  logic       armed;

  initial begin
    dir_op = '{2'b10, 2'b01, 2'b11, 2'b11};
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; clr_err = 1'b0; inj = 2'b00;
    rst_hold = 0; wait_cnt = 0; armed = 1'b0;
    for (int u = 0; u < 2; u++) model_reset(u);
    repeat (2) @(negedge clk);
    for (int u = 0; u < 2; u++) check_outs(u);
    rst = 1'b1;
    for (int u = 0; u < 2; u++) model_step(u);

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) check_outs(u);

      if (cyc == 1500 || cyc == 2600 || cyc == 3400) begin
        armed = 1'b1;
        wait_cnt = 0;
      end

      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst = 1'b1;
        else continue;
      end else if (armed) begin
        wait_cnt++;
        // Prefer hitting the first cycle of service with a backlog queued.
        if ((m_age[0] == 1 && m_n[0] >= 3) || wait_cnt > 200) begin
          #2 rst = 1'b0;
          #1;
          for (int u = 0; u < 2; u++) model_reset(u);
          for (int u = 0; u < 2; u++) check_outs(u);
          rst_hold = 2;
          armed = 1'b0;
          continue;
        end
      end

      if (cyc < 4) begin
        cmd_valid = 1'b1;
        cmd_op    = dir_op[cyc];
      end else begin
        cmd_valid = ($urandom_range(0, 3) != 0);
        cmd_op    = 2'($urandom_range(0, 3));
      end
      clr_err = (cyc >= 600) && ($urandom_range(0, 7) == 0);
      for (int u = 0; u < 2; u++) inj[u] = (cyc >= 600) && ($urandom_range(0, 5) == 0);
      for (int u = 0; u < 2; u++) model_step(u);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
